// File: rtl/sync_fifo_fwft_pkg.sv
// Shared constants, status bundle and parameter-legality helpers for the
// first-word-fall-through FIFO.
package sync_fifo_fwft_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 256;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic s_ready;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, s_ready: 1'b1};

    // Pointers and count carry one bit beyond the address so that a completely
    // full RAM can be told apart from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit afull_legal(input int thresh, input int depth);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Valid/ready write and read channels plus occupancy status of the FIFO.
// The slave modport is the FIFO's own view; master is the surrounding logic.
interface sync_fifo_fwft_if
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
);
    import sync_fifo_fwft_pkg::*;

    localparam int CNT_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             almost_full;

    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, count, full, empty, almost_full
    );

    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, count, full, empty, almost_full
    );

endinterface

// File: rtl/sync_fifo_fwft_ram.sv
// One-clock simple dual-port RAM with a registered read port that holds its
// last value when no read is issued; only the read register is reset.
module simple_dual_port_ram
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: RAM pointers, occupancy count, registered
// status flags and the fetch logic that keeps the RAM read register filled.
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic            clk,
    input  logic            rst,
    sync_fifo_fwft_if.slave bus
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;
    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_CNT = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] ONE = PTR_W'(1);

    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_fwft: DEPTH must be a power of two and at least 4");
    end

    if (!afull_legal(AFULL_THRESH, DEPTH)) begin : g_bad_afull
        $error("sync_fifo_fwft: AFULL_THRESH must lie in 1..DEPTH");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count_q;
    logic [PTR_W-1:0] count_next;
    logic             m_valid_q;
    fifo_flags_t      flags_q;
    fifo_flags_t      flags_next;
    logic             push;
    logic             pop;
    logic             ram_nonempty;
    logic             fetch;
    logic [WIDTH-1:0] rdata;

    assign push = bus.s_valid && flags_q.s_ready;
    assign pop  = m_valid_q && bus.m_ready;

    // The RAM read register is the output stage, so a read may only be issued
    // when that register is free or is being emptied in this same cycle.
    // Reads never collide with writes: the RAM can only hold DEPTH words when
    // the FIFO is full, and then no push is accepted.
    assign ram_nonempty = (wr_ptr != rd_ptr);
    assign fetch        = ram_nonempty && (!m_valid_q || bus.m_ready);

    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + ONE;
            2'b01:   count_next = count_q - ONE;
            default: count_next = count_q;
        endcase
    end

    always_comb begin
        flags_next             = FLAGS_RESET;
        flags_next.full        = (count_next == DEPTH_CNT);
        flags_next.empty       = (count_next == '0);
        flags_next.almost_full = (count_next >= AFULL_CNT);
        flags_next.s_ready     = (count_next != DEPTH_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            flags_q   <= FLAGS_RESET;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (fetch) begin
                m_valid_q <= 1'b1;
            end else if (pop) begin
                m_valid_q <= 1'b0;
            end
            count_q <= count_next;
            flags_q <= flags_next;
        end
    end

    simple_dual_port_ram #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (bus.s_data),
        .re    (fetch),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rdata)
    );

    assign bus.m_data      = rdata;
    assign bus.m_valid     = m_valid_q;
    assign bus.count       = count_q;
    assign bus.full        = flags_q.full;
    assign bus.empty       = flags_q.empty;
    assign bus.almost_full = flags_q.almost_full;
    assign bus.s_ready     = flags_q.s_ready;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: a vector table for the basic
// latency/hold behaviour, then scoreboard-driven streaming and corner sequences.
module tb_sync_fifo_fwft;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int AFULL = DEPTH - 4;

    logic clk;
    logic rst;

    sync_fifo_fwft_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_fwft #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] sb[$];
    int m_cnt;
    int m_ram;
    bit m_mv;
    int popped;
    int pushed;

    typedef struct {
        logic             sv;
        logic [WIDTH-1:0] sd;
        logic             mr;
        logic             exp_mv;
        logic             chk_data;
        logic [WIDTH-1:0] exp_data;
        int               exp_count;
        logic             exp_empty;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] expStatus();
        logic [31:0] s;
        s = {18'd0, 9'(m_cnt), (m_cnt == DEPTH), (m_cnt == 0), (m_cnt >= AFULL), (m_cnt != DEPTH), m_mv};
        return s;
    endfunction

    function automatic logic [31:0] dutStatus();
        logic [31:0] s;
        s = {18'd0, bus.count, bus.full, bus.empty, bus.almost_full, bus.s_ready, bus.m_valid};
        return s;
    endfunction

    // Called just after a rising edge: check status, drive one cycle, advance the model.
    task automatic applyStimulus(input logic sv, input logic [WIDTH-1:0] sd, input logic mr);
        bit m_push;
        bit m_pop;
        bit m_fetch;
        logic [WIDTH-1:0] exp;
        checkOutput("status", dutStatus(), expStatus());
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        m_push  = sv && (m_cnt != DEPTH);
        m_pop   = m_mv && mr;
        m_fetch = (m_ram > 0) && (!m_mv || mr);
        if (m_pop) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp = sb.pop_front();
                checkOutput("pop_data", 32'(bus.m_data), 32'(exp));
                popped++;
            end
        end
        if (m_push) begin
            sb.push_back(sd);
            pushed++;
        end
        m_ram = m_ram + int'(m_push) - int'(m_fetch);
        m_cnt = m_cnt + int'(m_push) - int'(m_pop);
        if (m_fetch) m_mv = 1'b1;
        else if (m_pop) m_mv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_ram = 0;
        m_mv = 1'b0;
        popped = 0;
        pushed = 0;
    endtask

    task automatic drain(input int budget);
        int cyc;
        cyc = 0;
        while ((sb.size() > 0) && (cyc < budget)) begin
            applyStimulus(1'b0, '0, 1'b1);
            cyc++;
        end
        checkOutput("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int max_cnt;
        int bubbles;
        int dut_pops;
        bit started;
        int cyc;
        logic sv;
        logic mr;
        logic [WIDTH-1:0] d;

        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b1};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 1, 1'b0};
        vecs[3]  = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1};
        vecs[4]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0};
        vecs[5]  = '{1'b1, 8'h23, 1'b0, 1'b1, 1'b1, 8'h21, 2, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h21, 3, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h21, 3, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 2, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h23, 1, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h23, 1, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1};

        doReset();
        checkOutput("reset_s_ready", 32'(bus.s_ready), 32'd1);
        checkOutput("reset_full", 32'(bus.full), 32'd0);
        checkOutput("reset_afull", 32'(bus.almost_full), 32'd0);

        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("vec%0d_m_valid", i), 32'(bus.m_valid), 32'(vecs[i].exp_mv));
            if (vecs[i].chk_data) begin
                checkOutput($sformatf("vec%0d_m_data", i), 32'(bus.m_data), 32'(vecs[i].exp_data));
            end
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vecs[i].exp_empty));
            bus.s_valid = vecs[i].sv;
            bus.s_data  = vecs[i].sd;
            bus.m_ready = vecs[i].mr;
            @(posedge clk);
            #1;
        end

        // Fill to capacity, try one extra word, then drain in order.
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, WIDTH'(i), 1'b0);
        end
        checkOutput("fill_full", 32'(bus.full), 32'd1);
        checkOutput("fill_s_ready", 32'(bus.s_ready), 32'd0);
        checkOutput("fill_count", 32'(bus.count), 32'(DEPTH));
        applyStimulus(1'b1, 8'hAA, 1'b0);
        checkOutput("overflow_count", 32'(bus.count), 32'(DEPTH));
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("pop_from_full_s_ready", 32'(bus.s_ready), 32'd1);
        drain(600);
        checkOutput("fill_popped", 32'(popped), 32'(DEPTH));
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("fill_end_m_valid", 32'(bus.m_valid), 32'd0);

        // Continuous streaming: one push and one pop per cycle once started.
        doReset();
        max_cnt = 0;
        bubbles = 0;
        dut_pops = 0;
        started = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.m_valid) dut_pops++;
            if (started && !bus.m_valid) bubbles++;
            if (bus.m_valid) started = 1'b1;
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
            applyStimulus(1'b1, WIDTH'(c), 1'b1);
        end
        checkOutput("stream_pops", 32'(dut_pops), 32'd998);
        checkOutput("stream_bubbles", 32'(bubbles), 32'd0);
        checkOutput("stream_max_count", 32'(max_cnt), 32'd2);
        drain(10);

        // Almost-full threshold edges.
        doReset();
        for (int i = 0; i < AFULL; i++) begin
            if (i == AFULL - 1) begin
                checkOutput("afull_before", 32'(bus.almost_full), 32'd0);
            end
            applyStimulus(1'b1, WIDTH'(i), 1'b0);
        end
        checkOutput("afull_rise", 32'(bus.almost_full), 32'd1);
        checkOutput("afull_count", 32'(bus.count), 32'(AFULL));
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("afull_fall", 32'(bus.almost_full), 32'd0);

        // Random traffic across many pointer wraps.
        doReset();
        cyc = 0;
        while ((pushed < 10000) && (cyc < 40000)) begin
            sv = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            d  = WIDTH'($urandom);
            if (pushed >= 10000) sv = 1'b0;
            applyStimulus(sv, d, mr);
            cyc++;
        end
        checkOutput("random_pushed", 32'(pushed), 32'd10000);
        drain(2000);
        checkOutput("random_popped", 32'(popped), 32'(pushed));

        // Reset in the middle of a stream, then confirm no stale data survives.
        doReset();
        for (int i = 0; i < 37; i++) begin
            applyStimulus(1'b1, WIDTH'(8'hC0 + i), 1'b0);
        end
        checkOutput("pre_reset_count", 32'(bus.count), 32'd37);
        rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs",
                    {19'd0, bus.s_ready, bus.m_valid, bus.m_data, bus.count, bus.full, bus.empty, bus.almost_full},
                    {19'd0, 1'b1, 1'b0, 8'h00, 9'd0, 1'b0, 1'b1, 1'b0});
        doReset();
        applyStimulus(1'b1, 8'h5A, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("post_reset_m_valid", 32'(bus.m_valid), 32'd1);
        checkOutput("post_reset_m_data", 32'(bus.m_data), 32'h5A);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_reset_popped", 32'(popped), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
